// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin GREEN->YELLOW->ALL_RED scheduler for roads A/B/C with BCD countdown.
// Define PED_WALK_EN to add the pedestrian WALK phase (Ped_Req in, Walk out).
module traffic_phase_scheduler #(
  parameter int CLK_DIV  = 25000000,
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10
) (
  input  logic       CLK_50MHz,
  input  logic       Res_n,
  input  logic [2:0] Req,
`ifdef PED_WALK_EN
  input  logic       Ped_Req,
  output logic       Walk,
`endif
  output logic [2:0] Grant,
  output logic [1:0] Phase,
  output logic [2:0] Lamp,
  output logic [3:0] Cnt_Tens,
  output logic [3:0] Cnt_Ones,
  output logic       Tick
);
  localparam int DW = CLK_DIV > 2 ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0] G_BCD = 8'((GREEN_T / 10) * 16 + GREEN_T % 10);
  localparam logic [7:0] Y_BCD = 8'((YELLOW_T / 10) * 16 + YELLOW_T % 10);
  localparam logic [7:0] A_BCD = 8'((ALLRED_T / 10) * 16 + ALLRED_T % 10);

  if (GREEN_T < 1 || GREEN_T > 99 || YELLOW_T < 1 || YELLOW_T > 99 ||
      ALLRED_T < 1 || ALLRED_T > 99 || WALK_T < 1 || WALK_T > 99) begin : g_bad_time
    $error("traffic_phase_scheduler: phase durations must lie in 1..99");
  end

`ifdef PED_WALK_EN
  typedef enum logic [2:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;
  localparam logic [7:0] W_BCD = 8'((WALK_T / 10) * 16 + WALK_T % 10);
  logic ped_q, walk_q, post_walk_q;
`else
  typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [2:0]    grant_q, lamp_q, pending_q, pending_d, mask, arb, rot;
  logic [1:0]    phase_q, rr_q, arb_idx, off;
  logic [2:0]    rr_sum;
  logic [3:0]    tens_q, ones_q, tens_dec, ones_dec;
  logic          cnt_one, exit_ok, go_green, to_walk;

  assign Tick     = div_q == DW'(CLK_DIV - 1);
  assign Grant    = grant_q;
  assign Phase    = phase_q;
  assign Lamp     = lamp_q;
  assign Cnt_Tens = tens_q;
  assign Cnt_Ones = ones_q;
`ifdef PED_WALK_EN
  assign Walk     = walk_q;
`endif

  assign cnt_one = tens_q == 4'd0 && ones_q == 4'd1;
  assign {tens_dec, ones_dec} = ones_q == 4'd0 ? {tens_q - 4'd1, 4'd9} : {tens_q, ones_q - 4'd1};

  // rot[0] is the road right after the rr pointer, rot[2] is the pointer road itself
  assign rot     = rr_q == 2'd0 ? {pending_q[0], pending_q[2], pending_q[1]} :
                   rr_q == 2'd1 ? {pending_q[1], pending_q[0], pending_q[2]} :
                                  {pending_q[2], pending_q[1], pending_q[0]};
  assign off     = rot[0] ? 2'd1 : rot[1] ? 2'd2 : 2'd3;
  assign rr_sum  = 3'(rr_q) + 3'(off);
  assign arb_idx = rr_sum >= 3'd3 ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
  assign arb     = |pending_q ? 3'b001 << arb_idx : 3'b000;

  assign exit_ok = Tick && (state_q == S_IDLE || (state_q == S_ALLRED && cnt_one));
`ifdef PED_WALK_EN
  assign to_walk = exit_ok && ped_q && !(post_walk_q && |pending_q);
`else
  assign to_walk = 1'b0;
`endif
  assign go_green  = exit_ok && |pending_q && !to_walk;
  assign mask      = (state_q == S_GREEN || state_q == S_YELLOW) ? grant_q : 3'b000;
  assign pending_d = (pending_q | (Req & ~mask)) & ~(go_green ? arb : 3'b000);

  always_ff @(posedge CLK_50MHz) begin
    if (!Res_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      grant_q   <= 3'b000;
      phase_q   <= 2'b00;
      lamp_q    <= 3'b100;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      pending_q <= 3'b000;
      rr_q      <= 2'd2;
`ifdef PED_WALK_EN
      ped_q       <= 1'b0;
      walk_q      <= 1'b0;
      post_walk_q <= 1'b0;
`endif
    end else begin
      div_q     <= Tick ? '0 : div_q + 1'b1;
      pending_q <= pending_d;
`ifdef PED_WALK_EN
      ped_q <= ped_q | Ped_Req;
`endif
      if (go_green) begin
        state_q          <= S_GREEN;
        grant_q          <= arb;
        rr_q             <= arb_idx;
        phase_q          <= 2'b01;
        lamp_q           <= 3'b001;
        {tens_q, ones_q} <= G_BCD;
`ifdef PED_WALK_EN
        post_walk_q <= 1'b0;
`endif
      end
`ifdef PED_WALK_EN
      else if (to_walk) begin
        state_q          <= S_WALK;
        grant_q          <= 3'b000;
        phase_q          <= 2'b11;
        lamp_q           <= 3'b100;
        walk_q           <= 1'b1;
        ped_q            <= 1'b0;
        post_walk_q      <= 1'b0;
        {tens_q, ones_q} <= W_BCD;
      end
`endif
      else if (Tick && state_q != S_IDLE) begin
        if (!cnt_one) begin
          {tens_q, ones_q} <= {tens_dec, ones_dec};
        end else if (state_q == S_GREEN) begin
          if ((Req & grant_q) != 3'b000 && (pending_q & ~grant_q) == 3'b000) begin
            {tens_q, ones_q} <= G_BCD;
          end else begin
            state_q          <= S_YELLOW;
            phase_q          <= 2'b10;
            lamp_q           <= 3'b010;
            {tens_q, ones_q} <= Y_BCD;
          end
        end else if (state_q == S_YELLOW) begin
          state_q          <= S_ALLRED;
          grant_q          <= 3'b000;
          phase_q          <= 2'b11;
          lamp_q           <= 3'b100;
          {tens_q, ones_q} <= A_BCD;
        end
`ifdef PED_WALK_EN
        else if (state_q == S_WALK) begin
          state_q          <= S_ALLRED;
          walk_q           <= 1'b0;
          post_walk_q      <= 1'b1;
          {tens_q, ones_q} <= A_BCD;
        end
`endif
        else begin
          state_q          <= S_IDLE;
          phase_q          <= 2'b00;
          lamp_q           <= 3'b100;
          {tens_q, ones_q} <= 8'h00;
`ifdef PED_WALK_EN
          post_walk_q <= 1'b0;
`endif
        end
      end
    end
  end
endmodule
